// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Division support is selected by the MULDIV_DIV_EN macro in the sequencer and datapath.
package muldiv_pkg;

  localparam int MULDIV_XLEN   = 32;
  localparam int MULDIV_CYCLES = MULDIV_XLEN;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  function automatic logic op_a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Double-width accumulator with one shift-add (multiply) or restoring shift-subtract
// (divide) step per cycle. The subtract path exists only when MULDIV_DIV_EN is defined.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic              i_step,
`ifdef MULDIV_DIV_EN
  input  logic              i_div,
`endif
  input  logic [XLEN-1:0]   i_mag_a,
  input  logic [XLEN-1:0]   i_mag_b,
  output logic [2*XLEN-1:0] o_acc
);

  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_mag_b;
  logic [XLEN:0]     w_add;
  logic [2*XLEN-1:0] w_mul_next;
  logic [2*XLEN-1:0] w_step_next;
`ifdef MULDIV_DIV_EN
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_div_next;
`endif

  // Multiply: low half holds the remaining multiplier bits, high half the running sum.
  // Divide: low half shifts in quotient bits, high half holds the partial remainder.
  always_comb begin
    w_add      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mag_b} : '0);
    w_mul_next = {w_add, r_acc[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    w_rem_sh = r_acc[2*XLEN-1:XLEN-1];
    w_diff   = w_rem_sh - {1'b0, r_mag_b};
    if (w_rem_sh >= {1'b0, r_mag_b}) begin
      w_div_next = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    end else begin
      w_div_next = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    end
    w_step_next = i_div ? w_div_next : w_mul_next;
`else
    w_step_next = w_mul_next;
`endif
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_acc   <= '0;
      r_mag_b <= '0;
    end else if (i_load) begin
      r_acc   <= {{XLEN{1'b0}}, i_mag_a};
      r_mag_b <= i_mag_b;
    end else if (i_step) begin
      r_acc <= w_step_next;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: FSM, step counter and core handshake around muldiv_datapath.
// DIV/DIVU/REM/REMU are implemented only when MULDIV_DIV_EN is defined; otherwise they return 0.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall,
  output muldiv_state_e   dbg_state
);

  localparam int CW = $clog2(XLEN);

  muldiv_state_e     r_state;
  muldiv_state_e     w_next;
  logic [CW-1:0]     r_count;
  logic [2:0]        r_funct3;
  logic              r_neg_res;
  logic [XLEN-1:0]   r_result;
  logic              w_load;
  logic              w_step;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [2*XLEN-1:0] w_acc;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_fix;
`ifdef MULDIV_DIV_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  logic              r_neg_rem;
  logic              r_div0;
  logic              r_ovf;
  logic [XLEN-1:0]   r_op_a;
  logic              w_div0;
  logic              w_ovf;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;

  assign w_div0 = funct3[2] && (op_b == '0);
  assign w_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) && (op_a == MIN_NEG) && (op_b == '1);
`endif

  // Handshake: start is a request sampled only in IDLE; done pulses for one cycle with
  // result valid and stays low otherwise; stall holds the core until the done cycle.
  assign w_sa    = op_a_signed(funct3) && op_a[XLEN-1];
  assign w_sb    = op_b_signed(funct3) && op_b[XLEN-1];
  assign w_mag_a = w_sa ? -op_a : op_a;
  assign w_mag_b = w_sb ? -op_b : op_b;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
`ifdef MULDIV_DIV_EN
          w_next = (w_div0 || w_ovf) ? ST_FIX : ST_CALC;
`else
          w_next = funct3[2] ? ST_DONE : ST_CALC;
`endif
        end
      end
      ST_CALC: if (r_count == '0) w_next = ST_FIX;
      ST_FIX:  w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (r_state != ST_IDLE);
    done   = (r_state == ST_DONE);
    stall  = (start && (r_state == ST_IDLE)) || (r_state == ST_CALC) || (r_state == ST_FIX);
    w_load = start && (r_state == ST_IDLE);
    w_step = (r_state == ST_CALC);
  end

  // Sign fix-up: product/quotient negated on differing signs, remainder follows dividend.
  always_comb begin
    w_prod = r_neg_res ? -w_acc : w_acc;
`ifdef MULDIV_DIV_EN
    w_quo = r_neg_res ? -w_acc[XLEN-1:0] : w_acc[XLEN-1:0];
    w_rem = r_neg_rem ? -w_acc[2*XLEN-1:XLEN] : w_acc[2*XLEN-1:XLEN];
    if (r_div0) begin
      w_quo = '1;
      w_rem = r_op_a;
    end else if (r_ovf) begin
      w_quo = MIN_NEG;
      w_rem = '0;
    end
`endif
    case (r_funct3)
      F3_MUL:                       w_fix = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_fix = w_prod[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
      F3_DIV, F3_DIVU:              w_fix = w_quo;
      F3_REM, F3_REMU:              w_fix = w_rem;
`endif
      default:                      w_fix = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_funct3  <= '0;
      r_neg_res <= 1'b0;
      r_result  <= '0;
`ifdef MULDIV_DIV_EN
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_ovf     <= 1'b0;
      r_op_a    <= '0;
`endif
    end else if (w_load) begin
      r_count   <= CW'(XLEN - 1);
      r_funct3  <= funct3;
      r_neg_res <= w_sa ^ w_sb;
`ifdef MULDIV_DIV_EN
      r_neg_rem <= w_sa;
      r_div0    <= w_div0;
      r_ovf     <= w_ovf;
      r_op_a    <= op_a;
`else
      if (funct3[2]) r_result <= '0;
`endif
    end else if (r_state == ST_CALC) begin
      if (r_count != '0) r_count <= r_count - CW'(1);
    end else if (r_state == ST_FIX) begin
      r_result <= w_fix;
    end
  end

  assign result    = r_result;
  assign dbg_state = r_state;

  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clk     (clk),
    .i_reset (reset),
    .i_load  (w_load),
    .i_step  (w_step),
`ifdef MULDIV_DIV_EN
    .i_div   (funct3[2]),
`endif
    .i_mag_a (w_mag_a),
    .i_mag_b (w_mag_b),
    .o_acc   (w_acc)
  );

endmodule
